// File: rtl/mul_arbiter_if.sv
// Requester, response and multiplier-side signal bundle for mul_arbiter.
interface mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     rsp_err;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_ready;
  logic [2*WIDTH-1:0]       mul_product;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_ready, mul_product,
    output req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_ready, mul_product,
    input  req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ requesters.
// Optional busy watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic         clk,
  input  logic         rst,
  mul_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] { IDLE, START, BUSY, RESP } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               any_req;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [PW-1:0]      product_q;
  logic               start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("mul_arbiter: TIMEOUT_CYC must be at least 1");
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;
`endif

  // First valid requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == pick) begin
        sel_a = bus.req_a[k*WIDTH +: WIDTH];
        sel_b = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      product_q   <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      busy_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= pick;
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          state   <= BUSY;
`ifdef MUL_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end
        BUSY: begin
          if (bus.mul_ready) begin
            product_q   <= bus.mul_product;
            rsp_valid_q <= NUM_REQ'(1) << grant;
            state       <= RESP;
`ifdef MUL_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (busy_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            product_q   <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant;
            state       <= RESP;
          end else begin
            busy_cnt    <= busy_cnt + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant]) begin
            rsp_valid_q <= '0;
            state       <= IDLE;
            ptr         <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept pulse is combinational so operands are taken in the granting cycle
  assign bus.req_ready   = (rst && state == IDLE && any_req) ? (NUM_REQ'(1) << pick) : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = product_q;
  assign bus.mul_start   = start_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.rsp_err     = err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized and directed self-checking bench for mul_arbiter against a
// transaction-level reference model.
module tb_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 40;
  localparam int PW = 2 * W;
  localparam int AW = N * W;

  logic clk = 1'b0;
  logic rst;

  mul_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // stimulus
  logic          stim_rst;
  logic [N-1:0]  stim_valid;
  logic [AW-1:0] stim_a;
  logic [AW-1:0] stim_b;
  logic [N-1:0]  stim_rsp_ready;
  int            lat_cfg;
  bit            spur_en;

  // multiplier environment: pending done pulse
  int            pend;
  logic [PW-1:0] pend_prod;

  // reference model: one transaction in flight at most
  int            m_ptr, m_g, m_age;
  bit            m_busy, m_done;
  logic [W-1:0]  m_a, m_b;
  logic [PW-1:0] m_prod;
  logic          m_err;

  // last observed DUT outputs
  logic [N-1:0]  obs_rr, obs_rv;
  logic          obs_st, obs_err;
  logic [PW-1:0] obs_prod;

  int n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'($signed(a)) * PW'($signed(b));
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_g = 0; m_age = 0; m_busy = 0; m_done = 0;
    m_a = '0; m_b = '0; m_prod = '0; m_err = 1'b0;
  endtask

  // One clock: drive at negedge, compare against model, advance model
  task automatic cycle();
    int            pk;
    logic          mr;
    logic [PW-1:0] mp;
    logic [N-1:0]  exp_rr, exp_rv;
    @(negedge clk);
    rst = stim_rst;
    bus.req_valid = stim_valid;
    bus.req_a     = stim_a;
    bus.req_b     = stim_b;
    bus.rsp_ready = stim_rsp_ready;
    mr = 1'b0;
    mp = PW'({$urandom, $urandom});
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin mr = 1'b1; mp = pend_prod; pend = -1; end
    end else if (spur_en && pend < 0 && !(m_busy && !m_done && m_age >= 2) &&
                 $urandom_range(0, 5) == 0) begin
      mr = 1'b1;
    end
    bus.mul_ready   = mr;
    bus.mul_product = mp;
    #1;
    if (!stim_rst) begin
      model_reset();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      chk("rst_mul_b", bus.mul_b, 0);
      chk("rst_rsp_product", bus.rsp_product, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
    end else begin
      pk     = rr_pick(stim_valid, m_ptr);
      exp_rr = (!m_busy && pk >= 0) ? N'(1) << pk : '0;
      exp_rv = (m_busy && m_done) ? N'(1) << m_g : '0;
      chk("req_ready", bus.req_ready, exp_rr);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("mul_start", bus.mul_start, (m_busy && m_age == 1));
      if (m_busy) begin
        chk("mul_a", bus.mul_a, m_a);
        chk("mul_b", bus.mul_b, m_b);
      end
      if (m_busy && m_done) begin
        chk("rsp_product", bus.rsp_product, m_prod);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (!m_busy) begin
        if (pk >= 0) begin
          m_busy = 1; m_done = 0; m_g = pk; m_age = 1;
          m_a = stim_a[pk*W +: W];
          m_b = stim_b[pk*W +: W];
        end
      end else if (m_done) begin
        if (stim_rsp_ready[m_g]) begin
          m_busy = 0;
          m_ptr  = (m_g + 1) % N;
        end
      end else begin
        if (m_age >= 2) begin
          if (mr) begin
            m_done = 1; m_prod = smul(m_a, m_b); m_err = 1'b0;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (m_age - 1 == TO) begin
            m_done = 1; m_prod = '0; m_err = 1'b1; pend = -1;
          end
`endif
        end
        m_age++;
      end
    end
    if (bus.mul_start) begin
      if (lat_cfg > 0) begin
        pend      = lat_cfg;
        pend_prod = smul(bus.mul_a, bus.mul_b);
      end else begin
        pend = -1;
      end
    end
    obs_rr = bus.req_ready; obs_rv = bus.rsp_valid; obs_st = bus.mul_start;
    obs_prod = bus.rsp_product; obs_err = bus.rsp_err;
  endtask

  task automatic do_reset();
    stim_rst = 1'b0;
    pend = -1;
    repeat (2) cycle();
    stim_rst = 1'b1;
  endtask

  // Run until a response is observed, dropping the request once granted
  task automatic run_txn(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (obs_rr != '0) stim_valid = '0;
      if (obs_rv != '0) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_rsp: got no response want one within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int exp_order[5];
    int n_gr, n_st, n_cnt;
    exp_order = '{0, 1, 2, 3, 0};
    n_chk = 0; n_fail = 0;
    rst = 1'b0; stim_rst = 1'b0;
    stim_valid = '0; stim_a = '0; stim_b = '0; stim_rsp_ready = '0;
    lat_cfg = 4; spur_en = 0; pend = -1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    bus.mul_ready = 1'b0; bus.mul_product = '0;
    model_reset();
    repeat (3) cycle();
    stim_rst = 1'b1;

    // single request on requester 2, multiplier latency 16
    stim_valid = 4'b0100; stim_rsp_ready = '1; lat_cfg = 16;
    stim_a[2*W +: W] = 16'd3; stim_b[2*W +: W] = 16'd5;
    run_txn("single", 40);
    chk("single_rsp_valid", obs_rv, 4'b0100);
    chk("single_product", obs_prod, 32'h0000000F);
    chk("single_err", obs_err, 0);

    // signed operands on requester 1
    stim_valid = 4'b0010; lat_cfg = 3;
    stim_a[1*W +: W] = 16'hFFFD; stim_b[1*W +: W] = 16'd7;
    run_txn("signed", 20);
    chk("signed_rsp_valid", obs_rv, 4'b0010);
    chk("signed_product", obs_prod, 32'hFFFFFFEB);

    // all requesters held high from reset: rotation order and start count
    do_reset();
    stim_valid = '1; stim_rsp_ready = '1; lat_cfg = 2;
    n_gr = 0; n_st = 0;
    for (int i = 0; i < 200 && n_gr < 5; i++) begin
      cycle();
      if (obs_st) n_st++;
      if (obs_rr != '0) begin order[n_gr] = oh_idx(obs_rr); n_gr++; end
    end
    cycle();
    if (obs_st) n_st++;
    stim_valid = '0;
    chk("rr_grants", n_gr, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), order[k], exp_order[k]);
    chk("rr_starts", n_st, 5);
    run_txn("rr_drain", 20);

    // response backpressure with other requesters pending
    stim_valid = 4'b0010; stim_rsp_ready = '0; lat_cfg = 2;
    stim_a[1*W +: W] = 16'd1000; stim_b[1*W +: W] = 16'd300;
    run_txn("bp", 20);
    stim_valid = '1; stim_rsp_ready = 4'b1101;
    n_gr = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (obs_rr != '0) n_gr++;
      chk("bp_hold_valid", obs_rv, 4'b0010);
      chk("bp_hold_product", obs_prod, 32'h000493E0);
    end
    chk("bp_no_grant", n_gr, 0);
    stim_rsp_ready = 4'b0010;
    cycle();
    chk("bp_release_valid", obs_rv, 4'b0010);
    cycle();
    chk("bp_idle_valid", obs_rv, 0);
    chk("bp_next_grant", obs_rr, 4'b0100);
    stim_valid = '0; stim_rsp_ready = '1;
    run_txn("bp_drain", 20);

    // reset four cycles into BUSY; late done pulse must be ignored
    do_reset();
    stim_valid = 4'b1000; lat_cfg = 10;
    n_cnt = 0;
    for (int i = 0; i < 10 && !obs_st; i++) begin
      cycle();
      if (obs_rr != '0) stim_valid = '0;
    end
    chk("abort_started", obs_st, 1);
    repeat (4) cycle();
    @(negedge clk);
    #2;
    stim_rst = 1'b0; rst = 1'b0;
    #1;
    chk("abort_req_ready", bus.req_ready, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_mul_start", bus.mul_start, 0);
    chk("abort_mul_a", bus.mul_a, 0);
    chk("abort_rsp_product", bus.rsp_product, 0);
    model_reset();
    stim_valid = '1;
    repeat (2) cycle();
    stim_rst = 1'b1; stim_valid = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_rv != '0) n_cnt++;
    end
    chk("abort_pulse_consumed", pend, -1);
    chk("abort_no_rsp", n_cnt, 0);
    stim_valid = '1;
    cycle();
    chk("abort_next_grant", obs_rr, 4'b0001);
    stim_valid = '0; lat_cfg = 3;
    run_txn("abort_drain", 20);

`ifdef MUL_ARB_TIMEOUT_EN
    // multiplier never answers: watchdog response
    do_reset();
    stim_valid = 4'b0001; lat_cfg = 0;
    for (int i = 0; i < 10 && !obs_st; i++) begin
      cycle();
      if (obs_rr != '0) stim_valid = '0;
    end
    n_cnt = 0;
    for (int i = 0; i < 60 && obs_rv == '0; i++) begin
      cycle();
      n_cnt++;
    end
    chk("tmo_cycles", n_cnt, TO + 1);
    chk("tmo_err", obs_err, 1);
    chk("tmo_product", obs_prod, 0);
    chk("tmo_rsp_valid", obs_rv, 4'b0001);
`endif

    // randomized traffic
    do_reset();
    spur_en = 1;
    for (int i = 0; i < 2500; i++) begin
      stim_valid     = N'($urandom);
      stim_a         = AW'({$urandom, $urandom});
      stim_b         = AW'({$urandom, $urandom});
      stim_rsp_ready = N'($urandom);
      lat_cfg        = $urandom_range(1, 8);
`ifdef MUL_ARB_TIMEOUT_EN
      if ($urandom_range(0, 15) == 0)
        lat_cfg = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(TO - 2, TO + 2);
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
